// File: rtl/speed_ctrl_pkg.sv
// Shared encodings for the speed/position counter: end-of-range modes,
// direction constants and the bounce FSM state type.
package speed_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_BOUNCE  = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic {
    ST_UP   = 1'b0,
    ST_DOWN = 1'b1
  } bounce_state_e;

endpackage

// File: rtl/speed_ctrl_mc_tick_gen.sv
// Run-time programmable prescaler; period is latched only at terminal count,
// reset or restart so a tick in progress is never truncated or stretched.
module tick_gen #(
  parameter int PRESC_W    = 26,
  parameter int RST_PERIOD = 10_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PRESC_W-1:0] period,
  input  logic               restart,
  output logic               step
);

  logic [PRESC_W-1:0] pcnt;
  logic [PRESC_W-1:0] period_active;
  logic [PRESC_W-1:0] last;

  // Periods 0 and 1 both give a terminal count of 0, i.e. a step every cycle.
  always_comb begin
    last = '0;
    if (period_active > PRESC_W'(1)) last = period_active - PRESC_W'(1);
  end

  // Held at terminal count while en=0, so a pending step fires on re-enable.
  assign step = en && (pcnt == last);

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt          <= '0;
      period_active <= PRESC_W'(RST_PERIOD);
    end else if (restart) begin
      pcnt          <= '0;
      period_active <= period;
    end else if (step) begin
      pcnt          <= '0;
      period_active <= period;
    end else if (en) begin
      pcnt <= pcnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/speed_ctrl_mc.sv
// Position counter with wrap / bounce / one-shot end handling, driven by the
// tick_gen prescaler; all outputs are registered and aligned with cnt.
module speed_ctrl_mc
  import speed_ctrl_pkg::*;
#(
  parameter int WIDTH      = 10,
  parameter int MAX_VAL    = 2**WIDTH - 1,
  parameter int PRESC_W    = 26,
  parameter int RST_PERIOD = 10_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PRESC_W-1:0] period,
  input  logic [1:0]         mode,
  input  logic               dir,
  input  logic               clr,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  output logic [WIDTH-1:0]   cnt,
  output logic               tick,
  output logic               wrap,
  output logic               done,
  output logic               cur_dir
);

  localparam logic [WIDTH-1:0] MAXW = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  mode_e         mode_s;
  logic          step;
  logic [WIDTH-1:0] cnt_q, cnt_d, target;
  logic          tick_q, tick_d, wrap_q, wrap_d, done_q, done_d;
  logic          cur_dir_q, cur_dir_d, armed_q, armed_d, go_up;
  bounce_state_e state_q, state_d;

  assign mode_s = mode_e'(mode);

  tick_gen #(
    .PRESC_W   (PRESC_W),
    .RST_PERIOD(RST_PERIOD)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .period (period),
    .restart(clr),
    .step   (step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
      done_q    <= 1'b0;
      cur_dir_q <= DIR_UP;
      state_q   <= ST_UP;
      armed_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
      done_q    <= done_d;
      cur_dir_q <= cur_dir_d;
      state_q   <= state_d;
      armed_q   <= armed_d;
    end
  end

  // armed_q: bounce was the mode at the last update, so state_q is valid;
  // otherwise the bounce direction is seeded from dir at the next step.
  always_comb begin
    cnt_d     = cnt_q;
    tick_d    = 1'b0;
    wrap_d    = 1'b0;
    done_d    = done_q;
    cur_dir_d = cur_dir_q;
    state_d   = state_q;
    armed_d   = armed_q;
    go_up     = 1'b0;
    target    = '0;
    if (clr) begin
      cnt_d     = (dir == DIR_DOWN) ? MAXW : '0;
      done_d    = 1'b0;
      cur_dir_d = dir;
      state_d   = (dir == DIR_DOWN) ? ST_DOWN : ST_UP;
      armed_d   = (mode_s == MODE_BOUNCE);
    end else if (load) begin
      cnt_d     = (load_val > MAXW) ? MAXW : load_val;
      done_d    = 1'b0;
      cur_dir_d = dir;
      state_d   = (dir == DIR_DOWN) ? ST_DOWN : ST_UP;
      armed_d   = (mode_s == MODE_BOUNCE);
    end else if (step) begin
      armed_d = (mode_s == MODE_BOUNCE);
      case (mode_s)
        MODE_BOUNCE: begin
          go_up  = armed_q ? (state_q == ST_UP) : (dir == DIR_UP);
          tick_d = 1'b1;
          if (go_up) begin
            if (cnt_q >= MAXW) begin
              cnt_d   = MAXW - ONE;
              state_d = ST_DOWN;
              wrap_d  = 1'b1;
            end else begin
              cnt_d   = cnt_q + ONE;
              state_d = ST_UP;
            end
          end else if (cnt_q == '0) begin
            cnt_d   = ONE;
            state_d = ST_UP;
            wrap_d  = 1'b1;
          end else begin
            cnt_d   = cnt_q - ONE;
            state_d = ST_DOWN;
          end
          cur_dir_d = (state_d == ST_DOWN);
        end
        MODE_ONESHOT: begin
          cur_dir_d = dir;
          target    = (dir == DIR_DOWN) ? '0 : MAXW;
          if (!done_q) begin
            if (cnt_q == target) begin
              done_d = 1'b1;
            end else begin
              cnt_d  = (dir == DIR_DOWN) ? cnt_q - ONE : cnt_q + ONE;
              tick_d = 1'b1;
              done_d = (cnt_d == target);
            end
          end
        end
        default: begin
          cur_dir_d = dir;
          tick_d    = 1'b1;
          if (dir == DIR_UP) begin
            if (cnt_q >= MAXW) begin
              cnt_d  = '0;
              wrap_d = 1'b1;
            end else begin
              cnt_d = cnt_q + ONE;
            end
          end else if (cnt_q == '0) begin
            cnt_d  = MAXW;
            wrap_d = 1'b1;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
      endcase
    end
  end

  always_comb begin
    cnt     = cnt_q;
    tick    = tick_q;
    wrap    = wrap_q;
    done    = done_q;
    cur_dir = cur_dir_q;
  end

endmodule
